// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the NOP returned on misaligned fetches, and the word-index width helper.
package imem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    // Bits needed to index DEPTH words; at least one so slices stay legal.
    function automatic int word_idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded program survives rst.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder with flush and program-load port.
// Optional misalignment trap enabled by defining IMEM_ALIGN_CHECK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a fetch request (req_ready=1)
// ST_WAIT | request latched, latency down-counter running
// ST_RESP | response presented and held until resp_ready
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_instr,
    output logic        resp_err,
    input  logic        flush,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam int          AW       = word_idx_w(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [15:0]   addr_q;
    logic [15:0]   rdata;
    logic [15:0]   word;
    logic          load_hit;
    logic          misalign;
    logic          unused_addr_bits;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr[AW:1]),
        .wdata (load_data),
        .raddr (addr_q[AW:1]),
        .rdata (rdata)
    );

    // A write landing on the RESP-entry edge must reach the response.
    assign load_hit = load_en && (load_addr[AW:1] == addr_q[AW:1]);
    assign word     = load_hit ? load_data : rdata;

    assign unused_addr_bits = ^{req_addr, load_addr, addr_q};

`ifdef IMEM_ALIGN_CHECK_EN
    logic err_q;

    assign misalign = addr_q[0];
    assign resp_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (state == ST_WAIT && cnt == 4'd0) begin
            err_q <= misalign;
        end else if (state == ST_RESP && resp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            addr_q     <= 16'h0000;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_instr <= 16'h0000;
        end else if (flush) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_instr <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_instr <= misalign ? NOP_INSTR : word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_instr <= 16'h0000;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: transaction-level model predicts ready,
// response timing and data; a negedge monitor pops expectations and compares.
module tb_imem_responder;

    localparam int L     = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_instr;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0;
    logic [15:0] load_data = 16'h0;

    imem_responder #(.LATENCY(L), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_err   (resp_err),
        .flush      (flush),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem_m [DEPTH];
    int          edge_n  = 0;
    bit          busy    = 1'b0;
    int          cur_due = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h edge=%0d", name, act, req, edge_n);
        end
    endtask

    // Reference: one outstanding fetch, answered L edges after acceptance,
    // released by resp_ready, dropped by flush or reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy = 1'b0;
            q.delete();
        end else begin
            edge_n++;
            if (load_en) mem_m[int'(load_addr >> 1) % DEPTH] = load_data;
            if (flush) begin
                busy = 1'b0;
                q.delete();
            end else if (busy) begin
                if (edge_n - 1 >= cur_due && resp_ready) busy = 1'b0;
            end else if (req_valid) begin
                busy    = 1'b1;
                cur_due = edge_n + L;
                q.push_back('{addr: req_addr, due: cur_due});
            end
        end
    end

    logic [15:0] held_i;
    logic        held_e;
    bit          have_cur = 1'b0;

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] ei;
        logic        ee;
        chk("req_ready", 16'(req_ready), 16'(!busy));
        chk("resp_valid", 16'(resp_valid), 16'(busy && edge_n >= cur_due));
        if (!resp_valid) begin
            have_cur = 1'b0;
            chk("idle_instr", resp_instr, 16'h0000);
            chk("idle_err", 16'(resp_err), 16'h0);
        end else if (!have_cur) begin
            if (q.size() == 0) begin
                chk("resp_unexpected", 16'(resp_valid), 16'h0);
            end else begin
                e  = q.pop_front();
                ei = mem_m[int'(e.addr >> 1) % DEPTH];
                ee = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
                if (e.addr[0]) begin
                    ei = 16'h0800;
                    ee = 1'b1;
                end
`endif
                chk("resp_latency", 16'(edge_n), 16'(e.due));
                chk("resp_instr", resp_instr, ei);
                chk("resp_err", 16'(resp_err), 16'(ee));
                held_i   = ei;
                held_e   = ee;
                have_cur = 1'b1;
            end
        end else begin
            chk("hold_instr", resp_instr, held_i);
            chk("hold_err", 16'(resp_err), 16'(held_e));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [15:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 16'(i * 2);
            load_data = 16'($urandom);
            tick();
        end
        load_en = 1'b0;

        // Directed fetch of a known word with immediate consumption.
        load_en = 1'b1; load_addr = 16'h0004; load_data = 16'h1234;
        tick();
        load_en = 1'b0;
        resp_ready = 1'b1;
        request(16'h0004);
        repeat (4) tick();

        // Back-pressure: response held 5 cycles while a new request waits.
        resp_ready = 1'b0;
        request(16'h0010);
        repeat (2) tick();
        req_valid = 1'b1; req_addr = 16'h0020;
        repeat (5) tick();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) tick();

        // Flush one cycle after acceptance, then a normal fetch.
        request(16'h0030);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        request(16'h0032);
        repeat (4) tick();

        // Writes to the in-flight address during WAIT and on RESP entry.
        request(16'h0040);
        load_en = 1'b1; load_addr = 16'h0040; load_data = 16'hBEEF;
        tick();
        load_en = 1'b0;
        repeat (4) tick();
        request(16'h0042);
        tick();
        load_en = 1'b1; load_addr = 16'h0042; load_data = 16'hCAFE;
        tick();
        load_en = 1'b0;
        repeat (3) tick();

        // Odd address: trap with NOP when enabled, otherwise word 1.
        request(16'h0003);
        repeat (4) tick();

        // Asynchronous reset mid-WAIT; loaded data must survive.
        request(16'h0050);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_resp_valid", 16'(resp_valid), 16'h0);
        chk("rst_resp_instr", resp_instr, 16'h0000);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        request(16'h0050);
        repeat (4) tick();

        for (int n = 0; n < 400; n++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = 16'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            load_en    = ($urandom_range(0, 4) == 0);
            load_addr  = 16'($urandom);
            load_data  = 16'($urandom);
            flush      = ($urandom_range(0, 24) == 0);
            tick();
        end

        req_valid = 1'b0; load_en = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        repeat (20) tick();
        chk("drain_empty", 16'(q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
